// File: rtl/hw1_pkg.sv
// ----------------------------------------------------------------------------
// hw1_pkg
//   Shared definitions for the HW1 De Morgan exerciser:
//   - state_t         : FSM state encoding (3 bits)
//   - IDX_*           : bit positions in the 5-bit gate-output vector
//                       {nA, nB, nAandnB, AorB, npAorB}, nA in the MSB
//   - demorgan_golden : expected gate outputs for a given {A,B}
// ----------------------------------------------------------------------------
package hw1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned OUT_W      = 5;
    localparam int unsigned IDX_NA     = 4;
    localparam int unsigned IDX_NB     = 3;
    localparam int unsigned IDX_NANDNB = 2;
    localparam int unsigned IDX_AORB   = 1;
    localparam int unsigned IDX_NPAORB = 0;

    function automatic logic [OUT_W-1:0] demorgan_golden(input logic a, input logic b);
        logic [OUT_W-1:0] v;
        v             = '0;
        v[IDX_NA]     = ~a;
        v[IDX_NB]     = ~b;
        v[IDX_NANDNB] = ~a & ~b;
        v[IDX_AORB]   = a | b;
        v[IDX_NPAORB] = ~(a | b);
        return v;
    endfunction

endpackage

// File: rtl/demorgan_exerciser_golden_model.sv
// ----------------------------------------------------------------------------
// demorgan_golden_model
//   Gate-level reference for the De Morgan block, built from primitives so
//   the expected values come from a structurally independent path.
//   Ports:
//     i_a, i_b  in   1      stimulus bits A, B
//     o_golden  out  5      {nA, nB, nAandnB, AorB, npAorB}
// ----------------------------------------------------------------------------
module demorgan_golden_model
    import hw1_pkg::*;
(
    input  logic             i_a,
    input  logic             i_b,
    output logic [OUT_W-1:0] o_golden
);

    logic w_na;
    logic w_nb;
    logic w_nandnb;
    logic w_aorb;
    logic w_npaorb;

    not u_na     (w_na, i_a);
    not u_nb     (w_nb, i_b);
    and u_nandnb (w_nandnb, w_na, w_nb);
    or  u_aorb   (w_aorb, i_a, i_b);
    not u_npaorb (w_npaorb, w_aorb);

    always_comb begin
        o_golden             = '0;
        o_golden[IDX_NA]     = w_na;
        o_golden[IDX_NB]     = w_nb;
        o_golden[IDX_NANDNB] = w_nandnb;
        o_golden[IDX_AORB]   = w_aorb;
        o_golden[IDX_NPAORB] = w_npaorb;
    end

endmodule

// File: rtl/demorgan_exerciser.sv
// ----------------------------------------------------------------------------
// demorgan_exerciser
//   Sweeps {A,B} through 00,01,10,11 (PASSES times), lets the gate block
//   settle for SETTLE_CYCLES, compares its five outputs to a golden model and
//   counts mismatching vectors (saturating). start/done handshake.
//   Ports:
//     clk, rst          in   1      clock, synchronous active-high reset
//     start             in   1      run request (accepted in IDLE or DONE)
//     busy, done, pass  out  1      run status; pass = done && err_count==0
//     err_count         out  ERR_W  mismatching vectors this run
//     A_drv, B_drv      out  1      stimulus to the gate block
//     nA_in .. npAorB_in in  1      gate block outputs
//   Optional (macro DEMORGAN_FAIL_LOG_EN):
//     first_fail_valid  out  1      a mismatch has been seen this run
//     first_fail_vec    out  2      {A,B} of the first mismatching vector
//     first_fail_mask   out  5      observed XOR golden at that vector
// ----------------------------------------------------------------------------
module demorgan_exerciser
    import hw1_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             A_drv,
    output logic             B_drv,
    input  logic             nA_in,
    input  logic             nB_in,
    input  logic             nAandnB_in,
    input  logic             AorB_in,
    input  logic             npAorB_in
`ifdef DEMORGAN_FAIL_LOG_EN
    ,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec,
    output logic [OUT_W-1:0] first_fail_mask
`endif
);

    // WAIT counts down from SETTLE_CYCLES-1 to 0, giving exactly SETTLE_CYCLES cycles.
    localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned SW          = (SETTLE_LOAD > 0) ? $clog2(SETTLE_LOAD + 1) : 1;
    localparam int unsigned PW          = (PASSES > 1) ? $clog2(PASSES) : 1;

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [PW-1:0]    r_pass;
    logic [SW-1:0]    r_settle;
    logic [ERR_W-1:0] r_err;
    logic             r_busy;
    logic             r_done;
    logic             r_a;
    logic             r_b;

    logic [OUT_W-1:0] w_golden;
    logic [OUT_W-1:0] w_obs;
    logic [OUT_W-1:0] w_mask;
    logic             w_mismatch;
    logic             w_last_pass;

    demorgan_golden_model u_golden (
        .i_a      (r_vec[1]),
        .i_b      (r_vec[0]),
        .o_golden (w_golden)
    );

    assign w_obs       = {nA_in, nB_in, nAandnB_in, AorB_in, npAorB_in};
    assign w_mask      = w_obs ^ w_golden;
    assign w_mismatch  = |w_mask;
    assign w_last_pass = (32'(r_pass) >= PASSES - 32'd1);

`ifdef DEMORGAN_FAIL_LOG_EN
    logic             r_ff_valid;
    logic [1:0]       r_ff_vec;
    logic [OUT_W-1:0] r_ff_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_ff_mask  <= '0;
        end else if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_ff_mask  <= '0;
        end else if (r_state == ST_CHECK && w_mismatch && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_vec   <= r_vec;
            r_ff_mask  <= w_mask;
        end
    end

    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_mask  = r_ff_mask;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_pass   <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_DRIVE;
                        r_vec   <= '0;
                        r_pass  <= '0;
                        r_err   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    {r_a, r_b} <= r_vec;
                    r_settle   <= SW'(SETTLE_LOAD);
                    r_state    <= (SETTLE_CYCLES > 0) ? ST_WAIT : ST_CHECK;
                end
                ST_WAIT: begin
                    if (r_settle == '0) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch && (r_err != '1)) begin
                        r_err <= r_err + 1'b1;
                    end
                    if (r_vec != 2'd3) begin
                        r_vec   <= r_vec + 2'd1;
                        r_state <= ST_DRIVE;
                    end else if (!w_last_pass) begin
                        r_vec   <= '0;
                        r_pass  <= r_pass + 1'b1;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_done && (r_err == '0);
    assign err_count = r_err;
    assign A_drv     = r_a;
    assign B_drv     = r_b;

endmodule

// File: tb/tb_demorgan_exerciser.sv
// ----------------------------------------------------------------------------
// tb_demorgan_exerciser
//   Three exerciser instances next to a behavioural gate block with selectable
//   faults: d_ (defaults), s_ (ERR_W=2, PASSES=2), z_ (SETTLE_CYCLES=0).
//   Fault codes: 0 correct, 1 npAorB tied 0, 2 nAandnB tied 1, 3 nA inverted.
//   Optional log checks under DEMORGAN_FAIL_LOG_EN.
// ----------------------------------------------------------------------------
module tb_demorgan_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default instance
    logic       d_rst, d_start, d_busy, d_done, d_pass, d_a, d_b;
    logic [7:0] d_err;
    logic [1:0] d_fault;
    logic       d_nA, d_nB, d_nAnB, d_AorB, d_nAorB;
    // saturation instance
    logic       s_rst, s_start, s_busy, s_done, s_pass, s_a, s_b;
    logic [1:0] s_err;
    logic [1:0] s_fault;
    logic       s_nA, s_nB, s_nAnB, s_AorB, s_nAorB;
    // zero-settle instance
    logic       z_rst, z_start, z_busy, z_done, z_pass, z_a, z_b;
    logic [7:0] z_err;
    logic [1:0] z_fault;
    logic       z_nA, z_nB, z_nAnB, z_AorB, z_nAorB;

    assign d_nA    = (d_fault == 2'd3) ? d_a : ~d_a;
    assign d_nB    = ~d_b;
    assign d_nAnB  = (d_fault == 2'd2) ? 1'b1 : (~d_a & ~d_b);
    assign d_AorB  = d_a | d_b;
    assign d_nAorB = (d_fault == 2'd1) ? 1'b0 : ~(d_a | d_b);

    assign s_nA    = (s_fault == 2'd3) ? s_a : ~s_a;
    assign s_nB    = ~s_b;
    assign s_nAnB  = (s_fault == 2'd2) ? 1'b1 : (~s_a & ~s_b);
    assign s_AorB  = s_a | s_b;
    assign s_nAorB = (s_fault == 2'd1) ? 1'b0 : ~(s_a | s_b);

    assign z_nA    = (z_fault == 2'd3) ? z_a : ~z_a;
    assign z_nB    = ~z_b;
    assign z_nAnB  = (z_fault == 2'd2) ? 1'b1 : (~z_a & ~z_b);
    assign z_AorB  = z_a | z_b;
    assign z_nAorB = (z_fault == 2'd1) ? 1'b0 : ~(z_a | z_b);

`ifdef DEMORGAN_FAIL_LOG_EN
    logic d_ffv, s_ffv, z_ffv;
    logic [1:0] d_ffvec, s_ffvec, z_ffvec;
    logic [4:0] d_ffm, s_ffm, z_ffm;
`endif

    demorgan_exerciser u_def (
        .clk(clk), .rst(d_rst), .start(d_start), .busy(d_busy), .done(d_done),
        .pass(d_pass), .err_count(d_err), .A_drv(d_a), .B_drv(d_b),
        .nA_in(d_nA), .nB_in(d_nB), .nAandnB_in(d_nAnB), .AorB_in(d_AorB),
        .npAorB_in(d_nAorB)
`ifdef DEMORGAN_FAIL_LOG_EN
        , .first_fail_valid(d_ffv), .first_fail_vec(d_ffvec), .first_fail_mask(d_ffm)
`endif
    );

    demorgan_exerciser #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) u_sat (
        .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_count(s_err), .A_drv(s_a), .B_drv(s_b),
        .nA_in(s_nA), .nB_in(s_nB), .nAandnB_in(s_nAnB), .AorB_in(s_AorB),
        .npAorB_in(s_nAorB)
`ifdef DEMORGAN_FAIL_LOG_EN
        , .first_fail_valid(s_ffv), .first_fail_vec(s_ffvec), .first_fail_mask(s_ffm)
`endif
    );

    demorgan_exerciser #(.SETTLE_CYCLES(0), .PASSES(1), .ERR_W(8)) u_s0 (
        .clk(clk), .rst(z_rst), .start(z_start), .busy(z_busy), .done(z_done),
        .pass(z_pass), .err_count(z_err), .A_drv(z_a), .B_drv(z_b),
        .nA_in(z_nA), .nB_in(z_nB), .nAandnB_in(z_nAnB), .AorB_in(z_AorB),
        .npAorB_in(z_nAorB)
`ifdef DEMORGAN_FAIL_LOG_EN
        , .first_fail_valid(z_ffv), .first_fail_vec(z_ffvec), .first_fail_mask(z_ffm)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_rst = 1'b1; s_rst = 1'b1; z_rst = 1'b1;
        tick(); tick();
        total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", d_busy); end
        total++; if (d_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", d_done); end
        total++; if (d_pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b expected 0", d_pass); end
        total++; if (d_err !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d expected 0", d_err); end
        total++; if ({d_a, d_b} !== 2'b00) begin bad++; $display("FAIL reset_ab: got %b expected 00", {d_a, d_b}); end
`ifdef DEMORGAN_FAIL_LOG_EN
        total++; if (d_ffv !== 1'b0) begin bad++; $display("FAIL reset_ffv: got %b expected 0", d_ffv); end
`endif
        d_rst = 1'b0; s_rst = 1'b0; z_rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_sweep();
        logic       exp_done;
        logic [1:0] exp_ab;
        d_fault = 2'd0;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        total++; if (d_busy !== 1'b1) begin bad++; $display("FAIL clean_busy_start: got %b expected 1", d_busy); end
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 1 || e == 5 || e == 9 || e == 13) begin
                exp_ab = 2'((e - 1) / 4);
                total++;
                if ({d_a, d_b} !== exp_ab) begin
                    bad++; $display("FAIL clean_ab_e%0d: got %b expected %b", e, {d_a, d_b}, exp_ab);
                end
            end
            exp_done = (e == 16);
            total++;
            if (d_done !== exp_done) begin
                bad++; $display("FAIL clean_done_e%0d: got %b expected %b", e, d_done, exp_done);
            end
        end
        total++; if (d_pass !== 1'b1) begin bad++; $display("FAIL clean_pass: got %b expected 1", d_pass); end
        total++; if (d_err !== 8'd0) begin bad++; $display("FAIL clean_err: got %0d expected 0", d_err); end
        total++; if ({d_a, d_b} !== 2'b11) begin bad++; $display("FAIL clean_final_ab: got %b expected 11", {d_a, d_b}); end
        total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL clean_busy_end: got %b expected 0", d_busy); end
    endtask

    task automatic test_npaorb_stuck0();
        int n;
        d_fault = 2'd1;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        n = 0;
        while (d_done !== 1'b1 && n < 100) begin tick(); n++; end
        total++; if (n != 16) begin bad++; $display("FAIL npaorb_latency: got %0d expected 16", n); end
        total++; if (d_err !== 8'd1) begin bad++; $display("FAIL npaorb_err: got %0d expected 1", d_err); end
        total++; if (d_pass !== 1'b0) begin bad++; $display("FAIL npaorb_pass: got %b expected 0", d_pass); end
`ifdef DEMORGAN_FAIL_LOG_EN
        total++; if (d_ffv !== 1'b1) begin bad++; $display("FAIL npaorb_ffv: got %b expected 1", d_ffv); end
        total++; if (d_ffvec !== 2'b00) begin bad++; $display("FAIL npaorb_ffvec: got %b expected 00", d_ffvec); end
        total++; if (d_ffm !== 5'b00001) begin bad++; $display("FAIL npaorb_ffmask: got %b expected 00001", d_ffm); end
`endif
    endtask

    task automatic test_nandnb_stuck1();
        int n;
        d_fault = 2'd2;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        n = 0;
        while (d_done !== 1'b1 && n < 100) begin tick(); n++; end
        total++; if (n != 16) begin bad++; $display("FAIL nandnb_latency: got %0d expected 16", n); end
        total++; if (d_err !== 8'd3) begin bad++; $display("FAIL nandnb_err: got %0d expected 3", d_err); end
        total++; if (d_pass !== 1'b0) begin bad++; $display("FAIL nandnb_pass: got %b expected 0", d_pass); end
`ifdef DEMORGAN_FAIL_LOG_EN
        total++; if (d_ffvec !== 2'b01) begin bad++; $display("FAIL nandnb_ffvec: got %b expected 01", d_ffvec); end
        total++; if (d_ffm !== 5'b00100) begin bad++; $display("FAIL nandnb_ffmask: got %b expected 00100", d_ffm); end
`endif
    endtask

    task automatic test_saturation();
        int n;
        s_fault = 2'd3;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        n = 0;
        while (s_done !== 1'b1 && n < 200) begin
            tick(); n++;
            if (n == 16) begin
                total++;
                if (s_busy !== 1'b1) begin bad++; $display("FAIL sat_busy_mid: got %b expected 1", s_busy); end
            end
        end
        total++; if (n != 32) begin bad++; $display("FAIL sat_latency: got %0d expected 32", n); end
        total++; if (s_err !== 2'd3) begin bad++; $display("FAIL sat_err: got %0d expected 3", s_err); end
        total++; if (s_pass !== 1'b0) begin bad++; $display("FAIL sat_pass: got %b expected 0", s_pass); end
`ifdef DEMORGAN_FAIL_LOG_EN
        total++; if (s_ffvec !== 2'b00) begin bad++; $display("FAIL sat_ffvec: got %b expected 00", s_ffvec); end
        total++; if (s_ffm !== 5'b10000) begin bad++; $display("FAIL sat_ffmask: got %b expected 10000", s_ffm); end
`endif
    endtask

    task automatic test_zero_settle();
        logic exp_done;
        z_fault = 2'd0;
        z_start = 1'b1;
        tick();
        z_start = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            // start pulse mid-run must be ignored
            if (e == 3) z_start = 1'b1;
            if (e == 4) z_start = 1'b0;
            exp_done = (e == 8);
            total++;
            if (z_done !== exp_done) begin
                bad++; $display("FAIL s0_done_e%0d: got %b expected %b", e, z_done, exp_done);
            end
        end
        total++; if (z_pass !== 1'b1) begin bad++; $display("FAIL s0_pass: got %b expected 1", z_pass); end
        total++; if ({z_a, z_b} !== 2'b11) begin bad++; $display("FAIL s0_final_ab: got %b expected 11", {z_a, z_b}); end

        // abort a run with rst at cycle 5
        z_fault = 2'd1;
        z_start = 1'b1;
        tick();
        z_start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        total++; if (z_err !== 8'd1) begin bad++; $display("FAIL s0_mid_err: got %0d expected 1", z_err); end
        total++; if ({z_a, z_b} !== 2'b01) begin bad++; $display("FAIL s0_mid_ab: got %b expected 01", {z_a, z_b}); end
        z_rst = 1'b1;
        tick();
        z_rst = 1'b0;
        total++; if (z_busy !== 1'b0) begin bad++; $display("FAIL s0_rst_busy: got %b expected 0", z_busy); end
        total++; if (z_done !== 1'b0) begin bad++; $display("FAIL s0_rst_done: got %b expected 0", z_done); end
        total++; if (z_pass !== 1'b0) begin bad++; $display("FAIL s0_rst_pass: got %b expected 0", z_pass); end
        total++; if (z_err !== 8'd0) begin bad++; $display("FAIL s0_rst_err: got %0d expected 0", z_err); end
        total++; if ({z_a, z_b} !== 2'b00) begin bad++; $display("FAIL s0_rst_ab: got %b expected 00", {z_a, z_b}); end

        // rst and start together: rst wins
        z_rst = 1'b1;
        z_start = 1'b1;
        tick();
        z_rst = 1'b0;
        z_start = 1'b0;
        total++; if (z_busy !== 1'b0) begin bad++; $display("FAIL s0_rst_start_busy: got %b expected 0", z_busy); end
        tick();
        total++; if (z_busy !== 1'b0) begin bad++; $display("FAIL s0_rst_start_idle: got %b expected 0", z_busy); end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        d_fault = 2'd2;
        d_rst = 1'b1;
        tick();
        d_rst = 1'b0;
        d_start = 1'b1;
        tick();
        for (int e = 1; e <= 50; e++) begin
            tick();
            exp_done = (e == 16) || (e == 33) || (e == 50);
            total++;
            if (d_done !== exp_done) begin
                bad++; $display("FAIL b2b_done_e%0d: got %b expected %b", e, d_done, exp_done);
            end
            if (e == 17) begin
                total++;
                if (d_err !== 8'd0) begin bad++; $display("FAIL b2b_err_clear: got %0d expected 0", d_err); end
`ifdef DEMORGAN_FAIL_LOG_EN
                total++;
                if (d_ffv !== 1'b0) begin bad++; $display("FAIL b2b_ffv_clear: got %b expected 0", d_ffv); end
`endif
            end
            if (e == 33) begin
                total++;
                if (d_err !== 8'd3) begin bad++; $display("FAIL b2b_err_run2: got %0d expected 3", d_err); end
            end
        end
        d_start = 1'b0;
    endtask

    initial begin
        d_rst = 1'b1; s_rst = 1'b1; z_rst = 1'b1;
        d_start = 1'b0; s_start = 1'b0; z_start = 1'b0;
        d_fault = 2'd0; s_fault = 2'd0; z_fault = 2'd0;
        test_reset();
        test_clean_sweep();
        test_npaorb_stuck0();
        test_nandnb_stuck1();
        test_saturation();
        test_zero_settle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
